// File: rtl/jtag_tap_scan.sv
// IEEE 1149.1-style TAP: 16-state controller, IR, BYPASS/IDCODE/boundary-scan DRs.
// All state updates on rising TCK; TDO, TDO_EN and pins_out are combinational from the registers.
module jtag_tap_scan #(
    parameter int          IR_LEN     = 4,
    parameter int          BSR_LEN    = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001,
    parameter int          FSM_SIZE   = 4
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [FSM_SIZE-1:0] state,
    output logic [IR_LEN-1:0]   ir_out,
    input  logic [BSR_LEN-1:0]  core_out,
    input  logic [BSR_LEN-1:0]  pins_in,
    output logic [BSR_LEN-1:0]  pins_out
);

    typedef enum logic [3:0] {
        S_EX2_DR = 4'h0,
        S_EX1_DR = 4'h1,
        S_SH_DR  = 4'h2,
        S_PAU_DR = 4'h3,
        S_SEL_IR = 4'h4,
        S_UPD_DR = 4'h5,
        S_CAP_DR = 4'h6,
        S_SEL_DR = 4'h7,
        S_EX2_IR = 4'h8,
        S_EX1_IR = 4'h9,
        S_SH_IR  = 4'hA,
        S_PAU_IR = 4'hB,
        S_RTI    = 4'hC,
        S_UPD_IR = 4'hD,
        S_CAP_IR = 4'hE,
        S_TLR    = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_BSR
    } dr_sel_e;

    localparam logic [IR_LEN-1:0] OP_EXTEST  = '0;
    localparam logic [IR_LEN-1:0] OP_IDCODE  = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] OP_SAMPLE  = IR_LEN'(2);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

    tap_state_e          state_q, state_d;
    logic [IR_LEN-1:0]   ir_shift_q, ir_shift_d;
    logic [IR_LEN-1:0]   ir_out_q, ir_out_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;
    logic [BSR_LEN-1:0]  bsr_shift_q, bsr_shift_d;
    logic [BSR_LEN-1:0]  bsr_upd_q, bsr_upd_d;
    dr_sel_e             dr_sel;

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_q     <= S_TLR;
            ir_out_q    <= OP_IDCODE;
            ir_shift_q  <= '0;
            bypass_q    <= 1'b0;
            idcode_q    <= '0;
            bsr_shift_q <= '0;
            bsr_upd_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_out_q    <= ir_out_d;
            ir_shift_q  <= ir_shift_d;
            bypass_q    <= bypass_d;
            idcode_q    <= idcode_d;
            bsr_shift_q <= bsr_shift_d;
            bsr_upd_q   <= bsr_upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_TLR:    state_d = TMS ? S_TLR    : S_RTI;
            S_RTI:    state_d = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: state_d = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: state_d = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  state_d = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: state_d = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: state_d = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: state_d = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: state_d = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: state_d = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: state_d = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  state_d = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: state_d = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: state_d = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: state_d = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: state_d = TMS ? S_SEL_DR : S_RTI;
            default:  state_d = S_TLR;
        endcase
    end

    // Unassigned opcodes fall back to BYPASS so the chain length stays defined.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_out_q == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir_out_q == OP_EXTEST || ir_out_q == OP_SAMPLE) begin
            dr_sel = DR_BSR;
        end
    end

    always_comb begin
        ir_shift_d  = ir_shift_q;
        ir_out_d    = ir_out_q;
        bypass_d    = bypass_q;
        idcode_d    = idcode_q;
        bsr_shift_d = bsr_shift_q;
        bsr_upd_d   = bsr_upd_q;
        case (state_q)
            S_CAP_IR: ir_shift_d = IR_CAPTURE;
            S_SH_IR: begin
                ir_shift_d             = ir_shift_q >> 1;
                ir_shift_d[IR_LEN-1]   = TDI;
            end
            S_UPD_IR: ir_out_d = ir_shift_q;
            S_CAP_DR: begin
                case (dr_sel)
                    DR_IDCODE: idcode_d    = IDCODE_VAL;
                    DR_BSR:    bsr_shift_d = pins_in;
                    default:   bypass_d    = 1'b0;
                endcase
            end
            S_SH_DR: begin
                case (dr_sel)
                    DR_IDCODE: begin
                        idcode_d     = idcode_q >> 1;
                        idcode_d[31] = TDI;
                    end
                    DR_BSR: begin
                        bsr_shift_d            = bsr_shift_q >> 1;
                        bsr_shift_d[BSR_LEN-1] = TDI;
                    end
                    default: bypass_d = TDI;
                endcase
            end
            S_UPD_DR: begin
                if (dr_sel == DR_BSR) begin
                    bsr_upd_d = bsr_shift_q;
                end
            end
            default: ;
        endcase
        // Falling into Test-Logic-Reset always restores the IDCODE instruction.
        if (state_d == S_TLR) begin
            ir_out_d = OP_IDCODE;
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (state_q == S_SH_IR) begin
            TDO = ir_shift_q[0];
        end else if (state_q == S_SH_DR) begin
            case (dr_sel)
                DR_IDCODE: TDO = idcode_q[0];
                DR_BSR:    TDO = bsr_shift_q[0];
                default:   TDO = bypass_q;
            endcase
        end
    end

    assign TDO_EN   = (state_q == S_SH_IR) || (state_q == S_SH_DR);
    assign state    = FSM_SIZE'(state_q);
    assign ir_out   = ir_out_q;
    assign pins_out = (ir_out_q == OP_EXTEST) ? bsr_upd_q : core_out;

endmodule

// File: doc/jtag_tap_scan.md
Name: jtag_tap_scan

Overview:
- Parametrised IEEE 1149.1-style Test Access Port. Successor to the standalone TAP state machine.
- Adds to the 16-state TAP FSM:
  - an instruction register of IR_LEN bits;
  - BYPASS, IDCODE and boundary-scan data registers;
  - serial TDI/TDO scan, and control of the boundary pins through EXTEST.
- Sits between the board test port and the core I/O ring.

Parameters:
- IR_LEN, 4, instruction register width (≥2).
- BSR_LEN, 8, boundary-scan register length (≥1).
- IDCODE_VAL, 32'h1234_5001, device ID; bit 0 must be 1.
- FSM_SIZE, 4, state output width (fixed at 4).

Ports:
- TCK  input  1  the block's only clock; all registers update on the rising edge.
- TRST  input  1  synchronous, active-high reset.
- TMS  input  1  mode select; sampled on each rising TCK.
- TDI  input  1  serial data in.
- TDO  output  1  serial data out.
- TDO_EN  output  1  high while in Shift-DR or Shift-IR.
- state  output  FSM_SIZE  current TAP state.
- ir_out  output  IR_LEN  active (updated) instruction.
- core_out  input  BSR_LEN  functional values driven by the core toward the pins.
- pins_in  input  BSR_LEN  values observed on the pins.
- pins_out  output  BSR_LEN  values driven to the pins.

Behaviour:
- State encodings (hex):
  - TLR F, RTI C.
  - SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5.
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
- Transitions, listed as TMS=0 / TMS=1:
  - TLR: RTI / TLR. RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR. SelIR: CapIR / TLR.
  - CapX: ShX / Ex1X. ShX: ShX / Ex1X.
  - Ex1X: PauX / UpdX. PauX: PauX / Ex2X. Ex2X: ShX / UpdX.
  - UpdX: RTI / SelDR.
- Five consecutive TMS=1 edges reach TLR from any state.
- TRST=1 at a rising edge:
  - state←F, ir_out←IDCODE opcode, IR shift←0, BSR update latch←0, bypass←0.
  - Overrides everything, including mid-shift.
- Entering TLR (TMS-driven) also loads ir_out←IDCODE.
- Opcodes:
  - EXTEST = all zeros.
  - IDCODE = 1.
  - SAMPLE/PRELOAD = 2.
  - BYPASS = all ones.
  - Any other opcode selects BYPASS.
- Action timing: each action happens on the rising edge at which the current state is the named state.
  - CapIR: IR shift register ← {0…0,01} (LSBs 01).
  - ShIR: IR shift ← {TDI, ir_shift[IR_LEN-1:1]}.
  - UpdIR: ir_out ← ir_shift.
  - CapDR: selected DR loads.
    - BYPASS: 0.
    - IDCODE: IDCODE_VAL.
    - EXTEST or SAMPLE: BSR shift ← pins_in.
  - ShDR: selected DR shifts right, TDI into MSB. BYPASS is 1 bit; IDCODE is 32 bits.
  - UpdDR: under EXTEST or SAMPLE, BSR update latch ← BSR shift. No effect otherwise.
  - Pause/Exit states: registers hold.
- TDO is combinational:
  - In ShIR: ir_shift[0].
  - In ShDR: LSB of the selected DR.
  - Otherwise 0.
  - TDO_EN = (state==ShIR || state==ShDR).
- pins_out = (ir_out==EXTEST) ? BSR update latch : core_out. The mux is combinational.
- Changing the instruction mid DR-scan is impossible: ir_out changes only in UpdIR.

Test Plan:
- TRST=1 for one edge, then TMS=1 held for 3 edges → state=F, ir_out=0001, TDO_EN=0, pins_out=core_out.
- TMS sequence 0,1,0,0 from TLR → states C,7,6,2. Then shift 32 edges with TMS=0 except TMS=1 on the last edge → TDO bits, LSB first, = 32'h1234_5001. Final state 1.
- IR scan of 1111 (TDI LSB first), reaching UpdIR then RTI → ir_out=1111. First TDO bits during ShIR = 1,0,0,0. DR scan of TDI pattern 1,0,1,1 → TDO = 0,1,0,1 (one-cycle bypass delay).
- Load SAMPLE with pins_in=8'hA5 → DR scan returns A5 LSB first while TDI shifts in 8'h3C. Then load EXTEST → pins_out=8'h3C. Load BYPASS → pins_out=core_out.
- From ShDR, TMS=1 for 5 edges → state=F and ir_out=0001.
- Assert TRST mid ShIR after 2 shifted bits → next state F. ir_out=0001. A subsequent IR capture reads …01 again.
